// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: load/store initiator between the MEM stage and a
// byte-addressed, word-organised data memory.
//  - Accepts byte/half/word loads and stores at any byte address.
//  - Issues word-aligned beats with byte enables. An access that crosses a
//    word boundary is split into two beats (BEAT0 = lower word, BEAT1 = next
//    word, wrapping at the top of memory).
//  - Load data from one or two beats is reassembled, shifted and
//    sign/zero-extended before it is returned.
//  - Optional macro MISALIGN_TRAP_EN: a misaligned request gets an error
//    response and no memory beat is issued.
//
// Handshakes:
//  - A request is taken on a rising edge where req_valid && req_ready.
//    req_ready is high only in IDLE.
//  - A memory beat completes on a rising edge where mem_valid && mem_ready.
//    mem_rdata is sampled on that same edge. All mem_* outputs hold steady
//    while mem_valid is high and mem_ready is low.
//  - rsp_valid is a single-cycle pulse with no back-pressure. rsp_rdata and
//    rsp_err are meaningful only while it is high.
//
// The state register 'state' (type state_t) is the FSM observation point.
module lsu_mem_ctrl #(
   parameter int ADDR_W = 14
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [1:0]        req_size,
   input  logic              req_unsigned,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              rsp_valid,
   output logic [31:0]       rsp_rdata,
   output logic              rsp_err,
   output logic              mem_valid,
   input  logic              mem_ready,
   output logic              mem_we,
   output logic [3:0]        mem_be,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata
);

`ifdef MISALIGN_TRAP_EN
   localparam logic TRAP_MISALIGN = 1'b1;
`else
   localparam logic TRAP_MISALIGN = 1'b0;
`endif

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BEAT0 = 2'd1,
      BEAT1 = 2'd2,
      RESP  = 2'd3
   } state_t;

   state_t state, state_nxt;

   // Fields of the request being served.
   logic              r_we;
   logic [1:0]        r_size;
   logic              r_uns;
   logic [ADDR_W-1:0] r_addr;
   logic [31:0]       r_wdata;
   logic [3:0]        r_mask;
   logic              r_err;
   logic              r_misal;
   logic [31:0]       lo_q;
   logic [31:0]       hi_q;

   // Decode of the incoming request.
   logic [1:0] req_off;
   logic [3:0] req_mask;
   logic       req_misal;
   logic       req_bad;
   logic       accept;

   // Datapath derived from the captured request.
   logic [1:0]        r_off;
   logic [7:0]        be_wide;
   logic [63:0]       wd_wide;
   logic [ADDR_W-1:0] word_addr;
   logic [ADDR_W-1:0] next_addr;
   logic [31:0]       rd;
   logic [31:0]       ld_ext;

   // Request decode: byte mask, boundary crossing, error.
   always_comb begin
      req_off = req_addr[1:0];
      case (req_size)
         2'd0:    req_mask = 4'b0001;
         2'd1:    req_mask = 4'b0011;
         2'd3:    req_mask = 4'b1111;
         default: req_mask = 4'b0000;
      endcase
      req_misal = ((req_size == 2'd1) && (req_off == 2'd3)) ||
                  ((req_size == 2'd3) && (req_off != 2'd0));
      req_bad   = (req_size == 2'd2) || (TRAP_MISALIGN && req_misal);
      accept    = req_valid && (state == IDLE);
   end

   // Lane steering for both beats and load-data reassembly.
   always_comb begin
      r_off     = r_addr[1:0];
      be_wide   = {4'b0000, r_mask} << r_off;
      wd_wide   = {32'h0, r_wdata} << {r_off, 3'b000};
      word_addr = {r_addr[ADDR_W-1:2], 2'b00};
      next_addr = word_addr + ADDR_W'(4);
      rd        = 32'({hi_q, lo_q} >> {r_off, 3'b000});
      case (r_size)
         2'd0:    ld_ext = {{24{~r_uns & rd[7]}},  rd[7:0]};
         2'd1:    ld_ext = {{16{~r_uns & rd[15]}}, rd[15:0]};
         default: ld_ext = rd;
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   // FSM next-state logic.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:  if (accept) state_nxt = req_bad ? RESP : BEAT0;
         BEAT0: if (mem_ready) state_nxt = r_misal ? BEAT1 : RESP;
         BEAT1: if (mem_ready) state_nxt = RESP;
         RESP:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Capture request fields on accept and read data on each completed beat.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_we    <= 1'b0;
         r_size  <= 2'd0;
         r_uns   <= 1'b0;
         r_addr  <= '0;
         r_wdata <= 32'h0;
         r_mask  <= 4'h0;
         r_err   <= 1'b0;
         r_misal <= 1'b0;
         lo_q    <= 32'h0;
         hi_q    <= 32'h0;
      end else begin
         if (accept) begin
            r_we    <= req_we;
            r_size  <= req_size;
            r_uns   <= req_unsigned;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            r_mask  <= req_mask;
            r_err   <= req_bad;
            r_misal <= req_misal;
            lo_q    <= 32'h0;
            hi_q    <= 32'h0;
         end
         if ((state == BEAT0) && mem_ready) lo_q <= mem_rdata;
         if ((state == BEAT1) && mem_ready) hi_q <= mem_rdata;
      end
   end

   // FSM outputs. Everything is forced to 0 outside the state that owns it.
   always_comb begin
      req_ready = 1'b0;
      rsp_valid = 1'b0;
      rsp_rdata = 32'h0;
      rsp_err   = 1'b0;
      mem_valid = 1'b0;
      mem_we    = 1'b0;
      mem_be    = 4'h0;
      mem_addr  = '0;
      mem_wdata = 32'h0;
      case (state)
         IDLE: req_ready = 1'b1;
         BEAT0: begin
            mem_valid = 1'b1;
            mem_we    = r_we;
            mem_be    = be_wide[3:0];
            mem_addr  = word_addr;
            mem_wdata = wd_wide[31:0];
         end
         BEAT1: begin
            mem_valid = 1'b1;
            mem_we    = r_we;
            mem_be    = be_wide[7:4];
            mem_addr  = next_addr;
            mem_wdata = wd_wide[63:32];
         end
         RESP: begin
            rsp_valid = 1'b1;
            rsp_err   = r_err;
            rsp_rdata = (r_err || r_we) ? 32'h0 : ld_ext;
         end
         default: ;
      endcase
   end

endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
- Load/store initiator between the pipeline MEM stage and the byte-addressed data memory.
- Takes byte, half and word load/store requests at any byte address.
- Issues word-aligned memory transactions with byte enables; splits misaligned accesses into two beats.
- For loads, assembles, shifts and sign/zero-extends the returned data back to the pipeline.

Parameters:
- ADDR_W, 14, byte-address width; memory size is 2^ADDR_W bytes.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-low reset (asserted when 0).
- req_valid  in  1  pipeline request valid.
- req_ready  out  1  block can accept a request (high only in IDLE).
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  0 = byte, 1 = half, 3 = word, 2 = reserved.
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data, right-justified.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  32  extended load data; 0 for stores and errors.
- rsp_err  out  1  reserved size, or misaligned access when the trap is enabled; qualified by rsp_valid.
- mem_valid  out  1  memory beat valid.
- mem_ready  in  1  memory accepts the beat; read data is valid in the same cycle.
- mem_we  out  1  beat is a write.
- mem_be  out  4  byte enables; bit k selects byte lane k (bits 8k+7:8k).
- mem_addr  out  ADDR_W  word address, low 2 bits always 0.
- mem_wdata  out  32  lane-aligned write data.
- mem_rdata  in  32  read data, little-endian lanes.

Behaviour:
- States: IDLE, BEAT0, BEAT1, RESP.
- Reset (reset==0 at an edge) -> IDLE.
  - Outputs after reset: req_ready=1; rsp_valid=0, rsp_rdata=0, rsp_err=0, mem_valid=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0.
  - Reset mid-operation aborts the access: mem_valid is 0 after that edge and no response is produced.
- Request capture:
  - Accept when req_valid && req_ready; latch all req_* fields.
  - off = addr[1:0].
  - mask = 4'b0001 (byte), 4'b0011 (half), 4'b1111 (word).
  - Misaligned: half with off==3, or word with off!=0.
- IDLE transitions on accept:
  - size==2 -> RESP with rsp_err=1.
  - Otherwise -> BEAT0.
- BEAT0:
  - mem_valid=1; mem_addr = {addr[ADDR_W-1:2],2'b00}; mem_we = req_we.
  - mem_be = (mask<<off)[3:0]; mem_wdata = wdata<<(8*off).
  - Hold all mem_* stable until mem_ready.
  - On mem_ready: latch mem_rdata as lo; go to BEAT1 if misaligned, else RESP.
- BEAT1:
  - mem_addr = word address + 4, modulo 2^ADDR_W (wraps to 0 at top of memory).
  - mem_be = (mask>>(4-off)); mem_wdata = wdata>>(8*(4-off)).
  - On mem_ready: latch mem_rdata as hi; go to RESP.
- RESP (exactly one cycle):
  - rsp_valid=1, then return to IDLE.
  - Load data: d = {hi,lo}>>(8*off) (hi=0 for single-beat accesses).
  - Byte result: d[7:0] extended; half: d[15:0] extended; word: d[31:0].
  - Stores: rsp_rdata=0.
- Latency:
  - Aligned access with mem_ready tied high: accept at cycle N, beat at N+1, rsp_valid at N+2.
  - Each misaligned split adds one cycle; memory stalls add one cycle per stall.
- req_ready=0 in BEAT0, BEAT1 and RESP, so there are no overlapping requests and back-to-back throughput is one request per 3 cycles minimum.
- mem_valid is never asserted with mem_be==0.

Optional Feature:
- MISALIGN_TRAP_EN defined:
  - Misaligned requests go IDLE -> RESP with rsp_err=1 and rsp_rdata=0.
  - No memory beat is issued; BEAT1 is unreachable.
- Not defined: misaligned requests are split as above, and rsp_err is set only for size==2.

Test Plan:
- Reset held low 2 cycles during a BEAT0 stall -> mem_valid=0 after the first reset edge, no rsp_valid, req_ready=1 after release.
- Aligned sw addr=0x0010, wdata=0xDEADBEEF -> one beat: mem_addr=0x0010, be=4'b1111, wdata=0xDEADBEEF; rsp_valid 2 cycles after accept.
- Load byte signed from addr=0x0013, memory word 0x80112233 -> be=4'b1000, rsp_rdata=0xFFFFFF80; same with req_unsigned=1 -> 0x00000080.
- Misaligned lw addr=0x0006, words 0x0004=0xAABBCCDD, 0x0008=0x11223344 -> beats at 0x0004 then 0x0008, rsp_rdata=0x3344AABB.
- Misaligned sh addr=0x3FFF, wdata=0x1234 -> beat0 addr=0x3FFC, be=4'b1000, wdata=0x34000000; beat1 addr=0x0000 (wrap), be=4'b0001, wdata lane0=0x12.
- req_size=2, then mem_ready held low 3 cycles on a sb -> first gives rsp_err=1 with no beat; second holds mem_* stable for 3 cycles before completing.
